// File: rtl/pc_gen_pkg.sv
// Shared constants for the fetch-address generator: reset/interrupt vectors,
// stall-vector geometry and chip-enable encodings.
package pc_gen_pkg;

  localparam logic [31:0] RST_VEC   = 32'hBFC0_0000;
  localparam logic [31:0] INT_VEC   = 32'hBFC0_0380;
  localparam int unsigned STALL_W   = 6;
  localparam int unsigned STALL_BIT = 0;

  typedef enum logic {
    CHIP_DISABLE = 1'b0,
    CHIP_ENABLE  = 1'b1
  } ce_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: top pointer plus saturating count.
// Push on full overwrites the oldest entry; pop on empty is ignored.
module pc_ras #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic              pop_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              valid_o
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] stack_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d, wr_ptr;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_en;
  logic              do_pop;

  assign valid_o = (cnt_q != '0);
  assign top_o   = stack_q[ptr_q];
  assign do_pop  = pop_i & valid_o;

  // Simultaneous push and valid pop replaces the top in place.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_ptr = ptr_q;
    if (push_i && do_pop) begin
      wr_en = 1'b1;
    end else if (push_i) begin
      wr_en  = 1'b1;
      wr_ptr = ptr_q + 1'b1;
      ptr_d  = ptr_q + 1'b1;
      if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + 1'b1;
    end else if (do_pop) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) stack_q[wr_ptr] <= push_addr_i;
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: prioritised redirect select, pending-redirect
// hold across stalls, sequential increment and RAS return prediction.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       INST_BYTES = 4,
  parameter logic [ADDR_W-1:0] RST_VEC    = ADDR_W'(pc_gen_pkg::RST_VEC),
  parameter logic [ADDR_W-1:0] INT_VEC    = ADDR_W'(pc_gen_pkg::INT_VEC),
  parameter bit                KEEP_MSB   = 1'b1,
  parameter int unsigned       STALL_W    = pc_gen_pkg::STALL_W,
  parameter int unsigned       STALL_BIT  = pc_gen_pkg::STALL_BIT,
  parameter int unsigned       RAS_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] ctrl_stall,
  input  logic               int_en,
  input  logic               eret_en,
  input  logic [ADDR_W-1:0]  epc,
  input  logic               br_en,
  input  logic [ADDR_W-1:0]  br_addr,
  input  logic               ras_push,
  input  logic [ADDR_W-1:0]  ras_push_addr,
  input  logic               ras_pop,
  input  logic               fetch_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               fetch_valid,
  output logic               ras_valid
);

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(INST_BYTES);

  ce_e               ce_q, ce_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic              pend_v_q, pend_v_d;
  logic [ADDR_W-1:0] pend_a_q, pend_a_d;
  logic              ce_on, stalled, adv;
  logic              redir_v;
  logic [ADDR_W-1:0] redir_a;
  logic              ras_pop_eff;
  logic [ADDR_W-1:0] ras_top;
  logic              unused_stall;

  assign unused_stall = ^ctrl_stall;

  pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .push_i      (ras_push),
    .push_addr_i (ras_push_addr),
    .pop_i       (ras_pop_eff),
    .top_o       (ras_top),
    .valid_o     (ras_valid)
  );

  // Chip-enable state: register / next-state / outputs.
  always_ff @(posedge clk) begin
    if (rst) ce_q <= CHIP_DISABLE;
    else     ce_q <= ce_d;
  end

  always_comb begin
    ce_d = CHIP_ENABLE;
  end

  always_comb begin
    ce_on       = (ce_q == CHIP_ENABLE);
    stalled     = ctrl_stall[STALL_BIT];
    ce          = ce_on;
    fetch_valid = ce_on & ~stalled;
  end

  assign adv         = ce_on & ~stalled & fetch_ready;
  assign ras_pop_eff = ras_pop & ce_on;

  always_comb begin
    redir_v = 1'b1;
    redir_a = INT_VEC;
    if      (int_en)                    redir_a = INT_VEC;
    else if (eret_en)                   redir_a = epc;
    else if (br_en)                     redir_a = br_addr;
    else if (ras_pop_eff && ras_valid)  redir_a = ras_top;
    else                                redir_v = 1'b0;
  end

  always_comb begin
    if (KEEP_MSB) pc_inc = {pc_q[ADDR_W-1], pc_q[ADDR_W-2:0] + INC[ADDR_W-2:0]};
    else          pc_inc = pc_q + INC;
  end

  always_comb begin
    pend_v_d = pend_v_q;
    pend_a_d = pend_a_q;
    if (!ce_on || adv) begin
      pend_v_d = 1'b0;
    end else if (redir_v) begin
      pend_v_d = 1'b1;
      pend_a_d = redir_a;
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (!ce_on)        pc_d = RST_VEC;
    else if (adv) begin
      if (redir_v)       pc_d = redir_a;
      else if (pend_v_q) pc_d = pend_a_q;
      else               pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RST_VEC;
      pend_v_q <= 1'b0;
      pend_a_q <= '0;
    end else begin
      pc_q     <= pc_d;
      pend_v_q <= pend_v_d;
      pend_a_q <= pend_a_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset release, redirects and priority,
// pending branch across stall, handshake hold, RAS, MSB-keeping wrap.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  ctrl_stall;
  logic        int_en, eret_en, br_en, ras_push, ras_pop, fetch_ready;
  logic [31:0] epc, br_addr, ras_push_addr;
  logic [31:0] pc;
  logic        ce, fetch_valid, ras_valid;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk           (clk),
    .rst           (rst),
    .ctrl_stall    (ctrl_stall),
    .int_en        (int_en),
    .eret_en       (eret_en),
    .epc           (epc),
    .br_en         (br_en),
    .br_addr       (br_addr),
    .ras_push      (ras_push),
    .ras_push_addr (ras_push_addr),
    .ras_pop       (ras_pop),
    .fetch_ready   (fetch_ready),
    .pc            (pc),
    .ce            (ce),
    .fetch_valid   (fetch_valid),
    .ras_valid     (ras_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ctrl_stall = '0; int_en = 0; eret_en = 0; br_en = 0;
    ras_push = 0; ras_pop = 0; fetch_ready = 1'b1;
    epc = '0; br_addr = '0; ras_push_addr = '0;

    // 1. reset release and sequential fetch
    step(); step();
    check("rst_ce", 32'(ce), 32'd0);
    check("rst_pc", pc, 32'hBFC0_0000);
    rst = 1'b0;
    step();
    check("rel_ce", 32'(ce), 32'd1);
    check("rel_pc", pc, 32'hBFC0_0000);
    step();
    check("seq1_pc", pc, 32'hBFC0_0004);
    check("seq1_fv", 32'(fetch_valid), 32'd1);
    step();
    check("seq2_pc", pc, 32'hBFC0_0008);

    // 2. branch held across a 3-cycle stall, overwritten by a newer one
    ctrl_stall = 6'b000001; br_en = 1'b1; br_addr = 32'h7000_0000;
    step();
    check("stall_pc0", pc, 32'hBFC0_0008);
    check("stall_fv", 32'(fetch_valid), 32'd0);
    br_addr = 32'h8000_1000;
    step();
    br_en = 1'b0;
    check("stall_pc1", pc, 32'hBFC0_0008);
    step();
    check("stall_pc2", pc, 32'hBFC0_0008);
    ctrl_stall = '0;
    step();
    check("pend_pc", pc, 32'h8000_1000);
    step();
    check("post_br_pc", pc, 32'h8000_1004);

    // 3. priority: interrupt over eret over branch; then eret over branch
    int_en = 1'b1; eret_en = 1'b1; br_en = 1'b1;
    epc = 32'h0040_0000; br_addr = 32'h8000_2000;
    step();
    check("int_pri_pc", pc, 32'hBFC0_0380);
    int_en = 1'b0;
    step();
    check("eret_pri_pc", pc, 32'h0040_0000);
    eret_en = 1'b0; br_en = 1'b0;
    step();
    check("post_eret_pc", pc, 32'h0040_0004);

    // 4. fetch_ready low holds pc and fetch_valid
    fetch_ready = 1'b0;
    step();
    check("hold1_pc", pc, 32'h0040_0004);
    check("hold1_fv", 32'(fetch_valid), 32'd1);
    step();
    check("hold2_pc", pc, 32'h0040_0004);
    check("hold2_fv", 32'(fetch_valid), 32'd1);
    fetch_ready = 1'b1;
    step();
    check("hold_adv_pc", pc, 32'h0040_0008);

    // 5. RAS: 5 pushes into depth 4, then 5 pops
    check("ras_empty", 32'(ras_valid), 32'd0);
    ras_push = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      ras_push_addr = 32'hA0 + 32'(i * 4);
      step();
    end
    ras_push = 1'b0;
    check("ras_push_pc", pc, 32'h0040_001C);
    check("ras_full_v", 32'(ras_valid), 32'd1);
    ras_pop = 1'b1;
    step();
    check("ras_pop1", pc, 32'h0000_00B0);
    step();
    check("ras_pop2", pc, 32'h0000_00AC);
    step();
    check("ras_pop3", pc, 32'h0000_00A8);
    step();
    check("ras_pop4", pc, 32'h0000_00A4);
    check("ras_drained_v", 32'(ras_valid), 32'd0);
    step();
    check("ras_pop5", pc, 32'h0000_00A8);
    ras_pop = 1'b0;

    // 6. MSB-keeping wrap, then reset with a pending branch
    br_en = 1'b1; br_addr = 32'hFFFF_FFFC;
    step();
    br_en = 1'b0;
    check("wrap_pre", pc, 32'hFFFF_FFFC);
    step();
    check("wrap_pc", pc, 32'h8000_0000);
    ctrl_stall = 6'b000001; br_en = 1'b1; br_addr = 32'h8000_3000;
    step();
    check("pend_rst_hold", pc, 32'h8000_0000);
    br_en = 1'b0; ctrl_stall = '0; rst = 1'b1;
    step();
    check("mid_rst_pc", pc, 32'hBFC0_0000);
    check("mid_rst_ce", 32'(ce), 32'd0);
    rst = 1'b0;
    step();
    check("mid_rel_pc", pc, 32'hBFC0_0000);
    step();
    check("dropped_br_pc", pc, 32'hBFC0_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
